// File: rtl/instr_seq_ctrl_if.sv
// instr_seq_ctrl_if: handshake/strobe bundle between the sequencer and the CPU datapath
interface instr_seq_ctrl_if #(
  parameter int INSTR_W = 16,
  parameter int ADDR_W  = 8,
  parameter int CNT_W   = 16
);
  logic               start_i;
  logic [INSTR_W-1:0] instr_i;
  logic               zero_i;
  logic               mem_ready_i;
  logic               en_pc_o;
  logic [1:0]         pc_ctrl_o;
  logic [ADDR_W-1:0]  offset_addr_o;
  logic               en_ir_o;
  logic               en_alu_o;
  logic [2:0]         alu_op_o;
  logic               en_reg_o;
  logic               mem_rd_o;
  logic               mem_wr_o;
  logic               busy_o;
  logic               halted_o;
  logic [CNT_W-1:0]   retired_o;
  modport master (
    input  start_i, instr_i, zero_i, mem_ready_i,
    output en_pc_o, pc_ctrl_o, offset_addr_o, en_ir_o, en_alu_o, alu_op_o,
           en_reg_o, mem_rd_o, mem_wr_o, busy_o, halted_o, retired_o
  );
  modport slave (
    output start_i, instr_i, zero_i, mem_ready_i,
    input  en_pc_o, pc_ctrl_o, offset_addr_o, en_ir_o, en_alu_o, alu_op_o,
           en_reg_o, mem_rd_o, mem_wr_o, busy_o, halted_o, retired_o
  );
endinterface

// File: rtl/instr_seq_ctrl.sv
// instr_seq_ctrl: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with Moore strobes
module instr_seq_ctrl #(
  parameter int INSTR_W = 16,
  parameter int ADDR_W  = 8,
  parameter int CNT_W   = 16
) (
  input logic              clk,
  input logic              rst_n,
  instr_seq_ctrl_if.master bus
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;
  logic [2:0]         state_q, state_d;
  logic [INSTR_W-1:0] ir_q;
  logic               zero_q;
  logic [CNT_W-1:0]   retired_q;
  logic [3:0]         op;
  logic               is_alu, is_ld, is_st, is_halt, taken, st_fetch, st_exec, st_mem, retire;
  logic               unused_ir_bits;
  assign op             = ir_q[INSTR_W-1 -: 4];
  assign unused_ir_bits = ^ir_q[INSTR_W-5:ADDR_W];
  assign is_alu   = (op != 4'h0) && !op[3];
  assign is_ld    = op == 4'h8;
  assign is_st    = op == 4'h9;
  assign is_halt  = op == 4'hF;
  assign taken    = (op == 4'hA) || ((op == 4'hB) && zero_q);
  assign st_fetch = state_q == S_FETCH;
  assign st_exec  = state_q == S_EXEC;
  assign st_mem   = state_q == S_MEM;
  // an instruction retires when leaving its last state, whichever that is for its class
  assign retire = (st_exec && !is_alu && !is_ld && !is_st) ||
                  (st_mem && bus.mem_ready_i && is_st) || (state_q == S_WB);
  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:   state_d = bus.start_i ? S_FETCH : S_IDLE;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC:   state_d = is_alu ? S_WB : (is_ld || is_st) ? S_MEM : is_halt ? S_HALT : S_FETCH;
      S_MEM:    state_d = !bus.mem_ready_i ? S_MEM : is_ld ? S_WB : S_FETCH;
      S_WB:     state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ir_q      <= '0;
      zero_q    <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (st_fetch) ir_q <= bus.instr_i;
      if (state_q == S_DECODE) zero_q <= bus.zero_i;
      if (retire) retired_q <= retired_q + 1'b1;
    end
  end
  assign bus.en_pc_o       = st_fetch || (st_exec && taken);
  assign bus.pc_ctrl_o     = st_fetch ? 2'b01 : (st_exec && taken) ? 2'b10 : 2'b00;
  assign bus.offset_addr_o = (st_exec && taken) ? ir_q[ADDR_W-1:0] : '0;
  assign bus.en_ir_o       = st_fetch;
  assign bus.en_alu_o      = st_exec && (is_alu || is_ld || is_st);
  assign bus.alu_op_o      = bus.en_alu_o ? op[2:0] : 3'b000;
  assign bus.en_reg_o      = state_q == S_WB;
  assign bus.mem_rd_o      = st_mem && is_ld;
  assign bus.mem_wr_o      = st_mem && is_st;
  assign bus.busy_o        = (state_q != S_IDLE) && (state_q != S_HALT);
  assign bus.halted_o      = state_q == S_HALT;
  assign bus.retired_o     = retired_q;
endmodule

// File: tb/tb_instr_seq_ctrl.sv
// tb_instr_seq_ctrl: directed stimulus pushes per-cycle expectations; a monitor pops and compares
module tb_instr_seq_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  instr_seq_ctrl_if ifc ();
  instr_seq_ctrl_if #(.CNT_W(4)) if4 ();
  instr_seq_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(ifc.master));
  instr_seq_ctrl #(.CNT_W(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.master));
  assign if4.start_i     = ifc.start_i;
  assign if4.instr_i     = ifc.instr_i;
  assign if4.zero_i      = ifc.zero_i;
  assign if4.mem_ready_i = ifc.mem_ready_i;
  typedef struct {
    logic [20:0] v;
    logic [15:0] r;
    string       nm;
  } exp_t;
  exp_t        q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [15:0] exp_ret = '0;
  // expected vector layout: {en_pc, pc_ctrl, offset, en_ir, en_alu, alu_op, en_reg, mem_rd, mem_wr, busy, halted}
  function automatic logic [20:0] ov(input logic pc_en, input logic [1:0] pcc, input logic [7:0] off,
                                     input logic ir, input logic alu, input logic [2:0] aop,
                                     input logic wb, input logic rd, input logic wr,
                                     input logic bsy, input logic hlt);
    return {pc_en, pcc, off, ir, alu, aop, wb, rd, wr, bsy, hlt};
  endfunction
  logic [20:0] v_idle, v_fetch, v_dec, v_wb, v_rd, v_wr, v_halt;
  initial begin
    v_idle  = '0;
    v_fetch = ov(1, 2'b01, 8'h00, 1, 0, 3'd0, 0, 0, 0, 1, 0);
    v_dec   = ov(0, 2'b00, 8'h00, 0, 0, 3'd0, 0, 0, 0, 1, 0);
    v_wb    = ov(0, 2'b00, 8'h00, 0, 0, 3'd0, 1, 0, 0, 1, 0);
    v_rd    = ov(0, 2'b00, 8'h00, 0, 0, 3'd0, 0, 1, 0, 1, 0);
    v_wr    = ov(0, 2'b00, 8'h00, 0, 0, 3'd0, 0, 0, 1, 1, 0);
    v_halt  = ov(0, 2'b00, 8'h00, 0, 0, 3'd0, 0, 0, 0, 0, 1);
  end
  function automatic logic [20:0] exec_vec(input logic [15:0] ins, input logic z);
    logic [3:0] op;
    op = ins[15:12];
    if (op >= 4'h1 && op <= 4'h7) return ov(0, 2'b00, 8'h00, 0, 1, op[2:0], 0, 0, 0, 1, 0);
    if (op == 4'h8) return ov(0, 2'b00, 8'h00, 0, 1, 3'd0, 0, 0, 0, 1, 0);
    if (op == 4'h9) return ov(0, 2'b00, 8'h00, 0, 1, 3'd1, 0, 0, 0, 1, 0);
    if (op == 4'hA || (op == 4'hB && z)) return ov(1, 2'b10, ins[7:0], 0, 0, 3'd0, 0, 0, 0, 1, 0);
    return v_dec;
  endfunction
  function automatic logic [20:0] act_vec();
    return {ifc.en_pc_o, ifc.pc_ctrl_o, ifc.offset_addr_o, ifc.en_ir_o, ifc.en_alu_o, ifc.alu_op_o,
            ifc.en_reg_o, ifc.mem_rd_o, ifc.mem_wr_o, ifc.busy_o, ifc.halted_o};
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic push(input logic [20:0] v, input string nm);
    exp_t e;
    e.v = v;
    e.r = exp_ret;
    e.nm = nm;
    q.push_back(e);
  endtask
  task automatic hold(input logic [20:0] v, input int n, input string nm);
    repeat (n) begin
      push(v, nm);
      @(negedge clk);
    end
  endtask
  // entered at the negedge just before FETCH; returns at a negedge with nothing pushed for the next sample
  task automatic run(input logic [15:0] ins, input logic z, input int w);
    logic [3:0] op;
    string      t;
    op = ins[15:12];
    t = $sformatf("%h", ins);
    ifc.instr_i = ins;
    push(v_fetch, {t, " fetch"});
    @(negedge clk);
    ifc.start_i = 1'b0;
    ifc.mem_ready_i = 1'b0;
    ifc.zero_i = z;
    push(v_dec, {t, " decode"});
    @(negedge clk);
    push(exec_vec(ins, z), {t, " exec"});
    @(negedge clk);
    if (op >= 4'h1 && op <= 4'h7) begin
      push(v_wb, {t, " wb"});
      @(negedge clk);
      exp_ret++;
    end else if (op == 4'h8 || op == 4'h9) begin
      push(op == 4'h8 ? v_rd : v_wr, {t, " mem"});
      @(negedge clk);
      for (int i = 0; i <= w; i++) begin
        ifc.mem_ready_i = (i == w);
        if (i < w) begin
          push(op == 4'h8 ? v_rd : v_wr, {t, " mem wait"});
          @(negedge clk);
        end
      end
      if (op == 4'h8) begin
        push(v_wb, {t, " wb"});
        @(negedge clk);
      end
      exp_ret++;
    end else begin
      exp_ret++;
    end
  endtask
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        chk({e.nm, " outs"}, 32'(act_vec()), 32'(e.v));
        chk({e.nm, " retired"}, 32'(ifc.retired_o), 32'(e.r));
        chk({e.nm, " retired4"}, 32'(if4.retired_o), 32'(e.r[3:0]));
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    ifc.start_i = 1'b1;
    ifc.instr_i = '0;
    ifc.zero_i = 1'b0;
    ifc.mem_ready_i = 1'b0;
    @(negedge clk);
    hold(v_idle, 2, "in reset start ignored");
    ifc.start_i = 1'b0;
    rst_n = 1'b1;
    hold(v_idle, 1, "idle");
    ifc.start_i = 1'b1;
    ifc.instr_i = 16'h1000;
    push(v_fetch, "abort fetch");
    @(negedge clk);
    ifc.start_i = 1'b0;
    push(v_dec, "abort decode");
    @(negedge clk);
    push(exec_vec(16'h1000, 1'b0), "abort exec");
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async abort outs", 32'(act_vec()), 32'(v_idle));
    chk("async abort retired", 32'(ifc.retired_o), 32'd0);
    push(v_idle, "after abort");
    @(negedge clk);
    rst_n = 1'b1;
    hold(v_idle, 1, "idle after abort");
    ifc.start_i = 1'b1;
    run(16'h2000, 1'b0, 0);
    run(16'hA05A, 1'b0, 0);
    run(16'hB033, 1'b1, 0);
    run(16'hB033, 1'b0, 0);
    run(16'h8000, 1'b0, 3);
    run(16'h9000, 1'b0, 0);
    run(16'h9000, 1'b1, 1);
    run(16'hC123, 1'b1, 0);
    run(16'h0000, 1'b0, 0);
    run(16'h7FFF, 1'b1, 0);
    run(16'hF000, 1'b0, 0);
    for (int i = 0; i < 4; i++) begin
      ifc.start_i = i[0];
      push(v_halt, "halt start ignored");
      @(negedge clk);
    end
    ifc.start_i = 1'b0;
    rst_n = 1'b0;
    exp_ret = '0;
    push(v_idle, "reset from halt");
    @(negedge clk);
    rst_n = 1'b1;
    hold(v_idle, 1, "idle before nops");
    ifc.start_i = 1'b1;
    repeat (16) run(16'h0000, 1'b0, 0);
    run(16'hF000, 1'b0, 0);
    hold(v_halt, 2, "final halt");
    @(posedge clk);
    #3;
    chk("queue drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
